// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - Shared pipeline op codes, mul/div FSM states and cycle counts
package muldiv_unit_pkg;

  localparam int DIV_CYCLES = 32;
  localparam int MUL_CYCLES = 32;

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_ADDU  = 6'd1,
    OP_SUBU  = 6'd2,
    OP_AND   = 6'd3,
    OP_LW    = 6'd4,
    OP_SW    = 6'd5,
    OP_MFHI  = 6'd16,
    OP_MTHI  = 6'd17,
    OP_MFLO  = 6'd18,
    OP_MTLO  = 6'd19,
    OP_MULT  = 6'd24,
    OP_MULTU = 6'd25,
    OP_DIV   = 6'd26,
    OP_DIVU  = 6'd27
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - Execute-stage mul/div request and result bundle
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic        in_valid;
  op_t         op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [4:0]  regw_in;
  logic [31:0] pc_in;
  logic        flush;
  logic        stall_in;
  logic        busy;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [4:0]  res_regw;
  logic [31:0] res_val;

  modport master (
    output in_valid, op, srcA, srcB, regw_in, pc_in, flush, stall_in,
    input  busy, res_valid, res_pc, res_regw, res_val
  );

  modport slave (
    input  in_valid, op, srcA, srcB, regw_in, pc_in, flush, stall_in,
    output busy, res_valid, res_pc, res_regw, res_val
  );

endinterface

// File: rtl/muldiv_unit_div_iter.sv
// rtl/muldiv_unit_div_iter.sv - Iterative unsigned radix-2 restoring divider core
module div_iter
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  localparam logic [4:0] LAST = 5'(DIV_CYCLES - 1);

  logic [31:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        active_q, active_d;
  logic [32:0] part;

  // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    part     = {rem_q, quo_q[31]};
    if (abort_i) begin
      active_d = 1'b0;
    end else if (start_i) begin
      rem_d    = '0;
      quo_d    = dividend_i;
      dsr_d    = divisor_i;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (part >= {1'b0, dsr_q}) begin
        rem_d = part[31:0] - dsr_q;
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = part[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == LAST) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_o = active_q && (cnt_q == LAST) && !abort_i;
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - Multi-cycle mul/div unit owning HI/LO; MULDIV_FAST_MULT_EN selects single-cycle multiply
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  muldiv_unit_if.slave bus
);

  muldiv_state_t state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, pc_q;
  logic          is_div_q, neg_quo_q, neg_rem_q;
  logic          op_mul, op_div, op_signed, mul_start, div_start, mul_last, div_done;
  logic [31:0]   a_mag, b_mag, quo_raw, rem_raw, quo_fix, rem_fix;
  logic [63:0]   prod_raw, prod_fix;
  logic          busy, res_valid;
  logic [31:0]   res_pc, res_val;
  logic [4:0]    res_regw;

  assign op_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_mag     = abs32(bus.srcA, op_signed);
  assign b_mag     = abs32(bus.srcB, op_signed);
  assign mul_start = (state_q == ST_IDLE) && bus.in_valid && !bus.flush && op_mul;
  assign div_start = (state_q == ST_IDLE) && bus.in_valid && !bus.flush && op_div;

`ifdef MULDIV_FAST_MULT_EN
  logic [31:0]        ma_q, mb_q;
  logic [63:0]        prod_q;
  logic signed [65:0] prod_full;

  assign prod_full = $signed({1'b0, ma_q}) * $signed({1'b0, mb_q});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ma_q   <= '0;
      mb_q   <= '0;
      prod_q <= '0;
    end else begin
      if (mul_start) begin
        ma_q <= a_mag;
        mb_q <= b_mag;
      end
      if (state_q == ST_MUL) prod_q <= prod_full[63:0];
    end
  end

  assign mul_last = 1'b1;
  assign prod_raw = prod_q;
`else
  logic [63:0] acc_q, mcand_q;
  logic [31:0] mplier_q;
  logic [4:0]  mcnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mcnt_q   <= '0;
    end else if (mul_start) begin
      acc_q    <= '0;
      mcand_q  <= {32'd0, a_mag};
      mplier_q <= b_mag;
      mcnt_q   <= '0;
    end else if (state_q == ST_MUL) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= {mcand_q[62:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[31:1]};
      mcnt_q   <= mcnt_q + 5'd1;
    end
  end

  assign mul_last = (mcnt_q == 5'(MUL_CYCLES - 1));
  assign prod_raw = acc_q;
`endif

  div_iter u_div (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (div_start),
    .abort_i    (bus.flush),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .done_o     (div_done),
    .quo_o      (quo_raw),
    .rem_o      (rem_raw)
  );

  assign prod_fix = neg_quo_q ? -prod_raw : prod_raw;
  assign quo_fix  = neg_quo_q ? -quo_raw : quo_raw;
  assign rem_fix  = neg_rem_q ? -rem_raw : rem_raw;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy      = 1'b0;
    res_valid = 1'b0;
    res_pc    = '0;
    res_regw  = '0;
    res_val   = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          case (bus.op)
            OP_MFHI: begin
              res_valid = 1'b1;
              res_pc    = bus.pc_in;
              res_regw  = bus.regw_in;
              res_val   = hi_q;
            end
            OP_MFLO: begin
              res_valid = 1'b1;
              res_pc    = bus.pc_in;
              res_regw  = bus.regw_in;
              res_val   = lo_q;
            end
            OP_MTHI: begin
              res_valid = 1'b1;
              res_pc    = bus.pc_in;
              if (!bus.stall_in) hi_d = bus.srcA;
            end
            OP_MTLO: begin
              res_valid = 1'b1;
              res_pc    = bus.pc_in;
              if (!bus.stall_in) lo_d = bus.srcA;
            end
            OP_MULT, OP_MULTU: begin
              busy    = 1'b1;
              state_d = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              busy    = 1'b1;
              state_d = ST_DIV;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        busy = 1'b1;
        if (bus.flush) state_d = ST_IDLE;
        else if (mul_last) state_d = ST_DONE;
      end
      ST_DIV: begin
        busy = 1'b1;
        if (bus.flush) state_d = ST_IDLE;
        else if (div_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        // A downstream stall holds the result here; HI/LO commit only on the exiting edge.
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          res_valid = 1'b1;
          res_pc    = pc_q;
          busy      = bus.stall_in;
          if (!bus.stall_in) begin
            state_d = ST_IDLE;
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              {hi_d, lo_d} = prod_fix;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      pc_q      <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (mul_start || div_start) begin
        pc_q      <= bus.pc_in;
        is_div_q  <= op_div;
        neg_quo_q <= op_signed && (bus.srcA[31] ^ bus.srcB[31]);
        neg_rem_q <= op_signed && bus.srcA[31];
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.res_valid = res_valid;
  assign bus.res_pc    = res_pc;
  assign bus.res_regw  = res_regw;
  assign bus.res_val   = res_val;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - Directed self-checking bench for muldiv_unit (honours MULDIV_FAST_MULT_EN)
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rw, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.srcA     = a;
    bus.srcB     = b;
    bus.regw_in  = rw;
    bus.pc_in    = pc;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.srcA     = '0;
    bus.srcB     = '0;
    bus.regw_in  = '0;
    bus.pc_in    = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " res_valid"}, bus.res_valid, 0);
    chk({tag, " res_pc"}, bus.res_pc, 0);
    chk({tag, " res_regw"}, bus.res_regw, 0);
    chk({tag, " res_val"}, bus.res_val, 0);
  endtask

  task automatic run(input string tag, input op_t o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] pc, input int lat);
    int bc;
    bit done;
    drive(o, a, b, 5'd0, pc);
    #1;
    bc = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.busy) begin
        bc++;
        nxt();
        idle_in();
        #1;
      end else begin
        done = 1'b1;
      end
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_cycles"}, bc, lat);
    chk({tag, " res_valid"}, bus.res_valid, 1);
    chk({tag, " res_pc"}, bus.res_pc, pc);
    nxt();
  endtask

  task automatic hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    drive(OP_MFHI, 32'd0, 32'd0, 5'd3, 32'h100);
    #1;
    chk({tag, " mfhi valid"}, bus.res_valid, 1);
    chk({tag, " hi"}, bus.res_val, eh);
    drive(OP_MFLO, 32'd0, 32'd0, 5'd2, 32'h104);
    #1;
    chk({tag, " mflo regw"}, bus.res_regw, 2);
    chk({tag, " lo"}, bus.res_val, el);
    idle_in();
    nxt();
  endtask

  initial begin
    bit seen;
    idle_in();
    bus.flush    = 1'b0;
    bus.stall_in = 1'b0;
    resetn       = 1'b0;
    #12;
    chk_quiet("reset");
    resetn = 1'b1;
    nxt();
    hilo("reset", 32'h0, 32'h0);

    drive(OP_ADDU, 32'd1, 32'd2, 5'd4, 32'h40);
    #1;
    chk("addu res_valid", bus.res_valid, 0);
    chk("addu busy", bus.busy, 0);
    idle_in();
    nxt();

    run("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'h200, MUL_LAT);
    hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h204, MUL_LAT);
    hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);
    run("divu", OP_DIVU, 32'd100, 32'd7, 32'h208, DIV_LAT);
    hilo("divu", 32'd2, 32'd14);
    run("div neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h20C, DIV_LAT);
    hilo("div neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div0", OP_DIV, 32'd5, 32'd0, 32'h210, DIV_LAT);
    hilo("div0", 32'd5, 32'hFFFF_FFFF);
    run("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h214, DIV_LAT);
    hilo("div ovf", 32'h0, 32'h8000_0000);

    drive(OP_MTHI, 32'h1234, 32'd0, 5'd0, 32'h300);
    #1;
    chk("mthi res_valid", bus.res_valid, 1);
    chk("mthi busy", bus.busy, 0);
    chk("mthi res_regw", bus.res_regw, 0);
    nxt();
    drive(OP_MFHI, 32'd0, 32'd0, 5'd7, 32'h304);
    #1;
    chk("mfhi after mthi val", bus.res_val, 32'h1234);
    chk("mfhi after mthi valid", bus.res_valid, 1);
    chk("mfhi after mthi busy", bus.busy, 0);
    chk("mfhi after mthi pc", bus.res_pc, 32'h304);
    idle_in();
    nxt();

    drive(OP_MTHI, 32'hAA, 32'd0, 5'd0, 32'h400);
    nxt();
    drive(OP_MTLO, 32'hBB, 32'd0, 5'd0, 32'h404);
    nxt();
    drive(OP_DIVU, 32'd100, 32'd7, 5'd0, 32'h408);
    nxt();
    idle_in();
    repeat (10) nxt();
    bus.flush = 1'b1;
    #1;
    chk("flush cycle busy", bus.busy, 1);
    nxt();
    bus.flush = 1'b0;
    #1;
    chk("after flush busy", bus.busy, 0);
    chk("after flush res_valid", bus.res_valid, 0);
    seen = 1'b0;
    repeat (40) begin
      nxt();
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    chk("flush stays quiet", seen, 0);
    hilo("flush", 32'hAA, 32'hBB);

    drive(OP_MULT, 32'd6, 32'd7, 5'd0, 32'h500);
    nxt();
    idle_in();
    bus.stall_in = 1'b1;
    repeat (MUL_LAT - 2) nxt();
    #1;
    chk("stall pre busy", bus.busy, 1);
    chk("stall pre res_valid", bus.res_valid, 0);
    for (int k = 0; k < 3; k++) begin
      nxt();
      #1;
      chk("stall hold res_valid", bus.res_valid, 1);
      chk("stall hold busy", bus.busy, 1);
      chk("stall hold res_pc", bus.res_pc, 32'h500);
    end
    nxt();
    bus.stall_in = 1'b0;
    #1;
    chk("stall release res_valid", bus.res_valid, 1);
    chk("stall release busy", bus.busy, 0);
    nxt();
    hilo("stall", 32'h0, 32'd42);

    drive(OP_MULT, 32'd3, 32'd5, 5'd0, 32'h600);
    nxt();
    idle_in();
    repeat (4) nxt();
    resetn = 1'b0;
    #1;
    chk_quiet("mid reset");
    nxt();
    resetn = 1'b1;
    nxt();
    hilo("post reset", 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit inside the execute stage, directly upstream of the memory stage.
- Owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Drives a stall to the front of the pipeline while an iterative operation runs.
- Hands a finished M_type-compatible result (pc, regw, valA) to the execute/memory pipeline register.

Parameters:
- DIV_CYCLES, 32, iterations of the radix-2 restoring divider; fixed, not user-tunable beyond 32.
- MUL_CYCLES, 32, iterations of the shift-add multiplier when the fast multiplier is compiled out.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  instruction in execute is a mul/div/HI-LO op
- op  in  6  decoded op code (OP_* enum from shared package)
- srcA  in  32  rs operand
- srcB  in  32  rt operand
- regw_in  in  5  destination register (MFHI/MFLO)
- pc_in  in  32  instruction pc
- flush  in  1  squash the in-flight op (exception/redirect)
- stall_in  in  1  downstream (memory stage) stall; hold the current result
- busy  out  1  unit occupied; execute and upstream stages must stall
- res_valid  out  1  result valid this cycle
- res_pc  out  32  pc of the completed op
- res_regw  out  5  destination register; 0 for ops with no GPR write
- res_val  out  32  GPR result (MFHI/MFLO); 0 otherwise

Behaviour:
- Reset (async, resetn=0):
  - HI=0, LO=0, state=IDLE.
  - busy=0, res_valid=0, res_pc=0, res_regw=0, res_val=0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - MFHI/MFLO/MTHI/MTLO complete in the same cycle (combinational res_*, busy=0).
  - MTHI/MTLO write HI/LO at the next clock edge, gated by !stall_in && !flush.
  - MULT/MULTU/DIV/DIVU latch operands, pc and signedness, then go to MUL or DIV. busy=1 from that cycle.
- Signed operands:
  - Take absolute values on entry.
  - Record sign_q = srcA[31]^srcB[31] and sign_r = srcA[31].
- MUL:
  - 64-bit accumulator with 32-bit shifted multiplier.
  - One bit per cycle; counter 0..MUL_CYCLES-1; then DONE.
- DIV:
  - Restoring: {rem, quo} shift left 1 per cycle.
  - rem >= |divisor| -> subtract, set quo bit.
  - After DIV_CYCLES iterations go to DONE.
- DONE:
  - Apply sign correction: product negated if sign_q; quotient negated if sign_q; remainder negated if sign_r.
  - Write HI/LO: mul {HI,LO}=product; div LO=quotient, HI=remainder.
  - res_valid=1, busy drops in the same cycle, and the FSM returns to IDLE.
  - If stall_in=1 in DONE: stay in DONE and keep busy=1. The HI/LO write happens once, on the exiting edge.
- Latency (issue to DONE): mul 1+MUL_CYCLES; div 1+DIV_CYCLES.
- Divide by zero: quotient=32'hFFFF_FFFF, remainder=dividend (unsigned magnitudes, then sign rules); no trap.
- Signed overflow: DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- flush:
  - Any state goes to IDLE next edge; busy=0 the next cycle.
  - HI/LO are unchanged and res_valid=0.
  - flush has priority over completion in the same cycle.
- An HI/LO op arriving while busy is impossible: upstream is stalled by busy. No queueing.
- MFHI/MFLO issued in the cycle after DONE see the updated HI/LO (register write precedes read).
- in_valid with a non-muldiv op: ignored, res_valid=0.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined:
  - MUL state completes in a single cycle using a registered 33x33 signed multiply.
  - Latency issue->DONE = 2; the shift-add datapath and MUL_CYCLES are unused.
- Undefined: iterative shift-add multiplier as above.
- Division is iterative in both builds.

Decomposition:
- Shared pipeline package:
  - OP_MULT/OP_MULTU/OP_DIV/OP_DIVU/OP_MFHI/OP_MFLO/OP_MTHI/OP_MTLO added to the existing op enum.
  - muldiv_state_t enum.
- One sub-module: div_iter, the iterative unsigned restoring divider core with start/done handshake, 32-bit magnitudes in, quotient/remainder out.
- Sign handling and HI/LO stay in muldiv_unit.

Test Plan:
- MULT srcA=-3 (0xFFFFFFFD), srcB=7 -> after 33 cycles (2 with fast) HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly for the latency; then MFLO regw=2 -> res_val=0xFFFFFFEB.
- DIVU 100/7 -> LO=14, HI=2 after 33 cycles; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 5/0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- MTHI 0x1234 then MFHI next cycle -> res_val=0x1234, res_valid=1 in the MFHI cycle, busy stays 0.
- flush at iteration 10 of DIVU (HI/LO preloaded 0xAA/0xBB) -> busy=0 next cycle, HI=0xAA, LO=0xBB unchanged, no res_valid.
- stall_in=1 for 3 cycles in DONE -> result held; HI/LO written once on release. Assert resetn=0 mid-MUL -> all outputs 0 immediately, HI=LO=0.
